// File: rtl/pwm_ctrl_pkg.sv
// Shared types and sizing for the PWM duty fade controller.
// State encoding, default duty width and default prescaler divide.
package pwm_ctrl_pkg;

    localparam int DUTY_W           = 8;
    localparam int DEFAULT_TICK_DIV = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2,
        HOLD = 2'd3
    } fade_state_t;

endpackage

// File: rtl/fade_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tick is high in the last count of each lap.
// Latency: tick is decoded from the registered count. No backpressure.
module fade_prescaler #(
    parameter int TICK_DIV = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    // TICK_DIV is a power of two, so natural rollover gives the wrap.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(TICK_DIV - 1));

endmodule

// File: rtl/pwm_fade_controller.sv
// Ramps the applied PWM duty toward the latest target in fixed steps at a tick-based interval.
// Latency: one cycle on the immediate path; first fade step lands one cycle after (interval+1)*TICK_DIV.
// No backpressure. PWM_SYNC_UPDATE_EN defers every duty change to the next pwm_period_start pulse.
module pwm_fade_controller
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH    = DUTY_W,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] target_duty,
    input  logic [WIDTH-1:0] fade_step,
    input  logic [WIDTH-1:0] fade_interval,
    input  logic             fade_en,
    input  logic             pwm_period_start,
    output logic [WIDTH-1:0] duty_out,
    output logic             busy,
    output logic             done
);

    fade_state_t      state, state_nx;
    logic [WIDTH-1:0] goal, goal_nx;
    logic [WIDTH-1:0] cur, cur_nx;
    logic [WIDTH-1:0] ivl_cnt, ivl_nx;
    logic             fin, fin_nx;
    logic             pre_clr;
    logic             tick;
    logic             changed;
    logic             immediate;
    logic             up;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   stepped;
    logic             pend;
    logic             unused_ok;

    fade_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pre_clr),
        .tick  (tick)
    );

    assign changed   = (target_duty != goal);
    assign immediate = !fade_en || (fade_step == '0);

    // One extra bit keeps the compare and the move free of wrap.
    assign up      = (goal >= cur);
    assign diff    = up ? ({1'b0, goal} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, goal});
    assign stepped = up ? ({1'b0, cur} + {1'b0, fade_step}) : ({1'b0, cur} - {1'b0, fade_step});

    always_comb begin
        state_nx = state;
        goal_nx  = goal;
        cur_nx   = cur;
        ivl_nx   = ivl_cnt;
        fin_nx   = 1'b0;
        pre_clr  = 1'b0;

        case (state)
            WAIT: begin
                if (tick) begin
                    if (ivl_cnt == '0) begin
                        state_nx = STEP;
                    end else begin
                        ivl_nx = ivl_cnt - WIDTH'(1);
                    end
                end
            end
            STEP: begin
                if (diff <= {1'b0, fade_step}) begin
                    cur_nx = goal;
`ifdef PWM_SYNC_UPDATE_EN
                    state_nx = HOLD;
`else
                    state_nx = IDLE;
                    fin_nx   = 1'b1;
`endif
                end else begin
                    cur_nx   = stepped[WIDTH-1:0];
                    ivl_nx   = fade_interval;
                    state_nx = WAIT;
                end
            end
            HOLD: begin
                if (pwm_period_start || !pend) begin
                    state_nx = IDLE;
                    fin_nx   = 1'b1;
                end
            end
            default: ;
        endcase

        if (changed) begin
            goal_nx = target_duty;
            if (immediate) begin
                cur_nx = target_duty;
`ifdef PWM_SYNC_UPDATE_EN
                state_nx = HOLD;
                fin_nx   = 1'b0;
`else
                state_nx = IDLE;
                fin_nx   = 1'b1;
`endif
            end else if (state == IDLE || state == HOLD) begin
                state_nx = WAIT;
                pre_clr  = 1'b1;
                ivl_nx   = fade_interval;
                fin_nx   = 1'b0;
            end else if (state == STEP) begin
                // The step just taken used the old goal; keep fading toward the new one.
                state_nx = WAIT;
                ivl_nx   = fade_interval;
                fin_nx   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            goal    <= '0;
            cur     <= '0;
            ivl_cnt <= '0;
            fin     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            goal    <= goal_nx;
            cur     <= cur_nx;
            ivl_cnt <= ivl_nx;
            fin     <= fin_nx;
            done    <= fin;
            busy    <= (state_nx != IDLE);
        end
    end

`ifdef PWM_SYNC_UPDATE_EN
    logic [WIDTH-1:0] dout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
            pend <= 1'b0;
        end else begin
            if (pwm_period_start && pend) begin
                dout <= cur;
            end
            if (cur_nx != cur) begin
                pend <= 1'b1;
            end else if (pwm_period_start) begin
                pend <= 1'b0;
            end
        end
    end

    assign duty_out  = dout;
    assign unused_ok = stepped[WIDTH];
`else
    assign pend      = 1'b0;
    assign duty_out  = cur;
    assign unused_ok = ^{stepped[WIDTH], pwm_period_start, pend};
`endif

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Directed bench for pwm_fade_controller with TICK_DIV=4; expected values are hand-derived per cycle.
module tb_pwm_fade_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] target_duty = 8'h00;
    logic [7:0] fade_step = 8'h00;
    logic [7:0] fade_interval = 8'h00;
    logic       fade_en = 1'b0;
    logic       pwm_period_start = 1'b0;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_fade_controller #(
        .WIDTH    (8),
        .TICK_DIV (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .target_duty      (target_duty),
        .fade_step        (fade_step),
        .fade_interval    (fade_interval),
        .fade_en          (fade_en),
        .pwm_period_start (pwm_period_start),
        .duty_out         (duty_out),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic go_zero();
        fade_en     = 1'b0;
        target_duty = 8'h00;
        repeat (3) next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (duty_out !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_duty k=%0d got %h want 00", k, duty_out);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_busy k=%0d got %b want 0", k, busy);
            end
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_done k=%0d got %b want 0", k, done);
            end
            next_cycle();
        end
    endtask

    task automatic test_immediate();
        fade_en     = 1'b0;
        fade_step   = 8'h10;
        target_duty = 8'h80;
        for (int k = 0; k <= 4; k++) begin
            next_cycle();
            n_cmp++;
            if (duty_out !== 8'h80) begin
                n_bad++;
                $display("FAIL imm_duty k=%0d got %h want 80", k, duty_out);
            end
            n_cmp++;
            if (done !== (k == 1)) begin
                n_bad++;
                $display("FAIL imm_done k=%0d got %b want %b", k, done, (k == 1));
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++;
                $display("FAIL imm_busy k=%0d got %b want 0", k, busy);
            end
        end
    endtask

    task automatic test_fade_up();
        logic [7:0] exp_d;
        go_zero();
        fade_en       = 1'b1;
        fade_step     = 8'h10;
        fade_interval = 8'h01;
        target_duty   = 8'h40;
        for (int k = 0; k <= 40; k++) begin
            next_cycle();
            exp_d = (k < 9) ? 8'h00 : (k < 17) ? 8'h10 : (k < 25) ? 8'h20 : (k < 33) ? 8'h30 : 8'h40;
            n_cmp++;
            if (duty_out !== exp_d) begin
                n_bad++;
                $display("FAIL up_duty k=%0d got %h want %h", k, duty_out, exp_d);
            end
            n_cmp++;
            if (busy !== (k < 33)) begin
                n_bad++;
                $display("FAIL up_busy k=%0d got %b want %b", k, busy, (k < 33));
            end
            n_cmp++;
            if (done !== (k == 34)) begin
                n_bad++;
                $display("FAIL up_done k=%0d got %b want %b", k, done, (k == 34));
            end
        end
    endtask

    task automatic test_nondiv();
        logic [7:0] exp_d;
        go_zero();
        fade_en       = 1'b1;
        fade_step     = 8'h30;
        fade_interval = 8'h01;
        target_duty   = 8'h50;
        for (int k = 0; k <= 20; k++) begin
            next_cycle();
            exp_d = (k < 9) ? 8'h00 : (k < 17) ? 8'h30 : 8'h50;
            n_cmp++;
            if (duty_out !== exp_d) begin
                n_bad++;
                $display("FAIL nondiv_up k=%0d got %h want %h", k, duty_out, exp_d);
            end
            n_cmp++;
            if (done !== (k == 18)) begin
                n_bad++;
                $display("FAIL nondiv_up_done k=%0d got %b want %b", k, done, (k == 18));
            end
        end
        target_duty = 8'h05;
        for (int k = 0; k <= 20; k++) begin
            next_cycle();
            exp_d = (k < 9) ? 8'h50 : (k < 17) ? 8'h20 : 8'h05;
            n_cmp++;
            if (duty_out !== exp_d) begin
                n_bad++;
                $display("FAIL nondiv_down k=%0d got %h want %h", k, duty_out, exp_d);
            end
            n_cmp++;
            if (done !== (k == 18)) begin
                n_bad++;
                $display("FAIL nondiv_down_done k=%0d got %b want %b", k, done, (k == 18));
            end
        end
    endtask

    task automatic test_retarget();
        logic [7:0] exp_d;
        go_zero();
        fade_en       = 1'b1;
        fade_step     = 8'h10;
        fade_interval = 8'h01;
        target_duty   = 8'hF0;
        for (int k = 0; k <= 40; k++) begin
            next_cycle();
            exp_d = (k < 9) ? 8'h00 : (k < 17) ? 8'h10 : (k < 25) ? 8'h20 : (k < 33) ? 8'h10 : 8'h00;
            n_cmp++;
            if (duty_out !== exp_d) begin
                n_bad++;
                $display("FAIL retarget_duty k=%0d got %h want %h", k, duty_out, exp_d);
            end
            n_cmp++;
            if (done !== (k == 34)) begin
                n_bad++;
                $display("FAIL retarget_done k=%0d got %b want %b", k, done, (k == 34));
            end
            if (k == 17) target_duty = 8'h00;
        end
    endtask

    task automatic test_reset_mid();
        go_zero();
        fade_en       = 1'b1;
        fade_step     = 8'h10;
        fade_interval = 8'h01;
        target_duty   = 8'h40;
        repeat (13) next_cycle();
        n_cmp++;
        if (duty_out !== 8'h10 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midfade_pre got duty=%h busy=%b want 10/1", duty_out, busy);
        end
        rst_n       = 1'b0;
        target_duty = 8'h00;
        fade_en     = 1'b0;
        next_cycle();
        n_cmp++;
        if (duty_out !== 8'h00) begin
            n_bad++;
            $display("FAIL midfade_rst_duty got %h want 00", duty_out);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midfade_rst_busy got %b want 0", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL midfade_rst_done got %b want 0", done);
        end
        rst_n = 1'b1;
        next_cycle();
        n_cmp++;
        if (duty_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL midfade_after got duty=%h busy=%b done=%b want 00/0/0", duty_out, busy, done);
        end
    endtask

    task automatic test_sync();
        fade_en     = 1'b0;
        target_duty = 8'h80;
        for (int k = 0; k <= 23; k++) begin
            next_cycle();
            pwm_period_start = (k == 19);
            n_cmp++;
            if (duty_out !== ((k < 20) ? 8'h00 : 8'h80)) begin
                n_bad++;
                $display("FAIL sync_duty k=%0d got %h want %h", k, duty_out, ((k < 20) ? 8'h00 : 8'h80));
            end
            n_cmp++;
            if (done !== (k == 21)) begin
                n_bad++;
                $display("FAIL sync_done k=%0d got %b want %b", k, done, (k == 21));
            end
            n_cmp++;
            if (busy !== (k < 20)) begin
                n_bad++;
                $display("FAIL sync_busy k=%0d got %b want %b", k, busy, (k < 20));
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef PWM_SYNC_UPDATE_EN
        test_sync();
`else
        test_immediate();
        test_fade_up();
        test_nondiv();
        test_retarget();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
